// File: rtl/pwm_counter_if.sv
// Control and status bundle for the PWM counter.
// The master side drives the configuration and controls; the slave side is the counter.
interface pwm_counter_if;
    logic        en;
    logic        count_reset;
    logic        upnotdown;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic [15:0] count_val;
    logic        period_done;
    logic        dir_active;

    modport master (
        output en,
        output count_reset,
        output upnotdown,
        output prescale,
        output period,
        input  count_val,
        input  period_done,
        input  dir_active
    );

    modport slave (
        input  en,
        input  count_reset,
        input  upnotdown,
        input  prescale,
        input  period,
        output count_val,
        output period_done,
        output dir_active
    );
endinterface

// File: rtl/pwm_counter.sv
// Prescaled up/down period counter feeding a PWM generator.
// Period, prescale and direction are shadowed and only re-sampled at a period boundary,
// on a synchronous clear, or on the first enabled cycle after the enable was low.
module pwm_counter (
    input  logic              clk,
    input  logic              rst_n,
    pwm_counter_if.slave      io_bus
);

    logic [15:0] r_count;
    logic        r_done;
    logic [7:0]  r_pre_cnt;
    logic [15:0] r_per_s;
    logic [7:0]  r_pre_s;
    logic        r_dir_s;
    logic        r_en_prev;

    logic        w_en_rise;
    logic [15:0] w_per_eff;
    logic [7:0]  w_pre_eff;
    logic        w_dir_eff;
    logic        w_tick;
    logic        w_boundary;
    logic        w_load;
    logic [15:0] w_count_next;
    logic [7:0]  w_pre_cnt_next;

    // Effective shadows: on an enable rising edge the fresh inputs count straight away.
    always_comb begin
        w_en_rise = io_bus.en & ~r_en_prev;
        w_per_eff = w_en_rise ? io_bus.period    : r_per_s;
        w_pre_eff = w_en_rise ? io_bus.prescale  : r_pre_s;
        w_dir_eff = w_en_rise ? io_bus.upnotdown : r_dir_s;

        // >= keeps the prescaler from running the long way round if a smaller
        // prescale was loaded while pre_cnt was already past it.
        w_tick = io_bus.en & ~io_bus.count_reset & (r_pre_cnt >= w_pre_eff);

        // Up counts wrap at (or past) the period; down counts reload at zero.
        w_boundary = w_tick & (w_dir_eff ? (r_count >= w_per_eff) : (r_count == 16'd0));
        w_load     = io_bus.count_reset | w_en_rise | w_boundary;
    end

    // Next count and prescaler values; clear beats enable and ticks.
    always_comb begin
        w_count_next   = r_count;
        w_pre_cnt_next = r_pre_cnt;
        if (io_bus.count_reset) begin
            w_count_next   = io_bus.upnotdown ? 16'd0 : io_bus.period;
            w_pre_cnt_next = 8'd0;
        end else if (io_bus.en) begin
            w_pre_cnt_next = w_tick ? 8'd0 : r_pre_cnt + 8'd1;
            if (w_boundary) begin
                w_count_next = w_dir_eff ? 16'd0 : io_bus.period;
            end else if (w_tick) begin
                w_count_next = w_dir_eff ? r_count + 16'd1 : r_count - 16'd1;
            end
        end
    end

    // State registers, shadows and the one-cycle boundary pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 16'd0;
            r_done    <= 1'b0;
            r_pre_cnt <= 8'd0;
            r_per_s   <= 16'd0;
            r_pre_s   <= 8'd0;
            r_dir_s   <= 1'b1;
            r_en_prev <= 1'b0;
        end else begin
            r_en_prev <= io_bus.en;
            r_count   <= w_count_next;
            r_pre_cnt <= w_pre_cnt_next;
            r_done    <= w_boundary;
            if (w_load) begin
                r_per_s <= io_bus.period;
                r_pre_s <= io_bus.prescale;
                r_dir_s <= io_bus.upnotdown;
            end
        end
    end

    assign io_bus.count_val   = r_count;
    assign io_bus.period_done = r_done;
    assign io_bus.dir_active  = r_dir_s;

endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench for pwm_counter: directed vector table, hand-written corner
// sequences, then randomized stimulus against a behavioural model.
module tb_pwm_counter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pwm_counter_if bus ();

    pwm_counter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int m_count, m_pre, m_per, m_pre_s, m_dir, m_en_prev, m_done;

    task automatic model_reset();
        m_count = 0; m_pre = 0; m_per = 0; m_pre_s = 0; m_dir = 1; m_en_prev = 0; m_done = 0;
    endtask

    task automatic model_load();
        m_per   = int'(bus.period);
        m_pre_s = int'(bus.prescale);
        m_dir   = int'(bus.upnotdown);
    endtask

    task automatic model_step();
        if (bus.count_reset) begin
            m_count = bus.upnotdown ? 0 : int'(bus.period);
            m_pre   = 0;
            m_done  = 0;
            model_load();
        end else if (bus.en) begin
            if (m_en_prev == 0) model_load();
            if (m_pre >= m_pre_s) begin
                m_pre = 0;
                if (m_dir != 0 ? (m_count >= m_per) : (m_count == 0)) begin
                    m_count = (m_dir != 0) ? 0 : int'(bus.period);
                    m_done  = 1;
                    model_load();
                end else begin
                    m_count = (m_dir != 0) ? m_count + 1 : m_count - 1;
                    m_done  = 0;
                end
            end else begin
                m_pre  = m_pre + 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
        end
        m_en_prev = int'(bus.en);
    endtask

    task automatic drive(input logic en, input logic cr, input logic dir,
                         input logic [7:0] pre, input logic [15:0] per);
        bus.en = en; bus.count_reset = cr; bus.upnotdown = dir;
        bus.prescale = pre; bus.period = per;
    endtask

    // One clock: model advances on the edge, outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] ec, input logic ed,
                       input logic edir);
        total++;
        if (bus.count_val !== ec || bus.period_done !== ed || bus.dir_active !== edir) begin
            bad++;
            $display("FAIL %s: got count_val=%0d period_done=%0b dir_active=%0b, want %0d %0b %0b",
                     name, bus.count_val, bus.period_done, bus.dir_active, ec, ed, edir);
        end
    endtask

    typedef struct {
        logic        en;
        logic        cr;
        logic        dir;
        logic [7:0]  pre;
        logic [15:0] per;
        logic [15:0] ec;
        logic        ed;
    } vec_t;

    vec_t tbl[21];
    int   down_a[7];
    int   down_b[5];

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'd0, 16'd0);

        // Up wrap with period 3, then prescale 2 with period 2 after a clear
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd3, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd3, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'd0, 16'd3, 16'd0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'd2, 16'd2, 16'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd2, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd2, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd2, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 8'd2, 16'd2, 16'd1, 1'b0};
        down_a = '{3, 2, 1, 0, 4, 3, 2};
        down_b = '{1, 0, 1, 0, 1};

        // Reset state while held in reset, then one idle cycle with en low
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", 16'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 16'd0, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].cr, tbl[i].dir, tbl[i].pre, tbl[i].per);
            step();
            chk($sformatf("vec%0d", i), tbl[i].ec, tbl[i].ed, 1'b1);
        end

        // Down count with a mid-period period change taking effect at the boundary
        drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd4);
        step();
        chk("down_clear", 16'd4, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 16'd4);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("down_a%0d", i), 16'(down_a[i]), (i == 4), 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 8'd0, 16'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("down_b%0d", i), 16'(down_b[i]), (i == 2 || i == 4), 1'b0);
        end

        // Enable freeze, then clear with enable high
        drive(1'b1, 1'b1, 1'b1, 8'd0, 16'd9);
        step();
        chk("en_clear0", 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'd0, 16'd9);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("en_run%0d", i), 16'(i), 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, 8'd0, 16'd9);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("en_hold%0d", i), 16'd5, 1'b0, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b1, 8'd0, 16'd9);
        step();
        chk("clear_no_pulse", 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'd0, 16'd9);
        step();
        chk("resume_after_clear", 16'd1, 1'b0, 1'b1);

        // Period zero: every tick is a boundary, with and without prescale, both directions
        drive(1'b1, 1'b1, 1'b1, 8'd0, 16'd0);
        step();
        chk("p0_clear", 16'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("p0_up%0d", i), 16'd0, 1'b1, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b1, 8'd1, 16'd0);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'd1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("p0_pre%0d", i), 16'd0, (i % 2 == 1), 1'b1);
        end
        drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd0);
        step();
        chk("p0_down_clear", 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("p0_down%0d", i), 16'd0, 1'b1, 1'b0);
        end

        // Asynchronous reset mid-count in down mode
        drive(1'b1, 1'b1, 1'b0, 8'd0, 16'd9);
        step();
        chk("pre_rst_load", 16'd9, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 16'd9);
        step();
        step();
        chk("pre_rst_count", 16'd7, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 16'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 8'd0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            bus.en          = ($urandom_range(7) != 0);
            bus.count_reset = ($urandom_range(15) == 0);
            if ($urandom_range(9) == 0) bus.upnotdown = ~bus.upnotdown;
            if ($urandom_range(5) == 0) bus.prescale = 8'($urandom_range(3));
            if ($urandom_range(7) == 0) bus.period = 16'($urandom_range(7));
            step();
            chk($sformatf("rand%0d", i), 16'(m_count), m_done[0], m_dir[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_counter.md
PWM_COUNTER -- requirements
Module: pwm_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports `clk` and `rst_n`.
REQ-002 clk  input  1  block clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  counter enable; 0 = freeze all state.
REQ-005 count_reset  input  1  synchronous clear request, single-cycle or level.
REQ-006 upnotdown  input  1  direction request; 1 = up, 0 = down.
REQ-007 prescale  input  8  tick divider; the counter advances once per (prescale+1) enabled cycles.
REQ-008 period  input  16  terminal count request; one count cycle spans period+1 values.
REQ-009 count_val  output  16  current count; registered; consumed by the PWM generator stage.
REQ-010 period_done  output  1  registered one-cycle pulse at each period boundary.
REQ-011 dir_active  output  1  direction currently in effect (shadowed upnotdown).

Function
REQ-012 The block SHALL hold shadow registers `per_s` (16), `pre_s` (8) and `dir_s` (1); all counting SHALL use the shadows, never the live inputs.
REQ-013 The block SHALL load the shadows from `period`, `prescale` and `upnotdown` in three cases: on a period boundary, on `count_reset`, and on the first enabled cycle after `en` was 0 (en rising edge).
REQ-014 An 8-bit prescaler `pre_cnt` SHALL increment on every enabled cycle, and a tick SHALL occur on the cycle where `pre_cnt == pre_s`, with `pre_cnt` returning to 0.
REQ-015 A prescale value of 0 SHALL produce a tick on every enabled cycle.
REQ-016 Up mode (`dir_s` = 1): on a tick, `count_val` SHALL increment while `count_val < per_s`; when `count_val == per_s` it SHALL wrap to 0, which is a period boundary.
REQ-017 Down mode (`dir_s` = 0): on a tick, `count_val` SHALL decrement while `count_val > 0`; when `count_val == 0` it SHALL reload the newly latched period value, which is a period boundary.
REQ-018 `period_done` SHALL be 1 for exactly the cycle after a boundary tick is registered, i.e. it is asserted coincident with `count_val` showing the wrapped or reloaded value, and SHALL be 0 otherwise.
REQ-019 When `per_s == 0`, `count_val` SHALL stay at 0 and every tick SHALL be a boundary.
REQ-020 A change to `period`, `prescale` or `upnotdown` mid-period SHALL have no effect until the next boundary; a new period smaller than the current count therefore never causes a skipped wrap.
REQ-021 With `en` = 0, `count_val`, `pre_cnt` and the shadows SHALL hold, and `period_done` SHALL be 0.
REQ-022 `count_reset` SHALL have priority over `en` and ticks; it SHALL clear `pre_cnt` to 0, load the shadows, and set `count_val` to 0 in up mode or to `period` in down mode (direction taken from the `upnotdown` input that same cycle), with no `period_done` pulse.
REQ-023 A tick SHALL NOT occur on the same cycle as `count_reset`; counting resumes on the following enabled cycles.
REQ-024 All arithmetic SHALL be unsigned 16-bit, and `count_val` SHALL never exceed `per_s` and never underflow below 0.
REQ-025 `dir_active` SHALL equal `dir_s`.

Reset
REQ-026 While `rst_n` = 0, the block SHALL force `count_val` = 0, `period_done` = 0, `pre_cnt` = 0, `per_s` = 0, `pre_s` = 0, `dir_s` = 1, `dir_active` = 1, and SHALL clear the en-edge history so that `en` = 1 after reset loads the shadows.
REQ-027 Reset asserted mid-period SHALL take effect immediately (asynchronously), and no `period_done` pulse SHALL be produced by it.

Verification
REQ-028 Up wrap: period=3, prescale=0, up, en=1 -> count_val 0,1,2,3,0,1...; period_done high exactly in the cycles where count_val returns to 0.
REQ-029 Prescale: period=2, prescale=2, up -> each value held 3 cycles; sequence 0,0,0,1,1,1,2,2,2,0; one pulse per 9 cycles.
REQ-030 Down with shadow: period=4, down -> 4,3,2,1,0,4...; change period to 1 when count_val=2 -> continues 1,0, then reloads 1 and runs 1,0,1,0.
REQ-031 Enable and clear: count at 5 (period=9), en=0 for 4 cycles -> holds at 5 with no pulse; then count_reset=1 with en=1 -> count_val=0, no pulse, and counting resumes on the next cycle.
REQ-032 Edge cases: period=0 -> count_val stays 0 and period_done pulses every tick; reset asserted mid-count -> all outputs 0 (dir_active=1) within the same cycle.
